// File: rtl/counter_share_arbiter_pkg.sv
// rtl/counter_share_arbiter_pkg.sv - shared state encodings and default sizes for the counter share arbiter
package counter_share_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_share_arbiter_if.sv
// rtl/counter_share_arbiter_if.sv - requester/status bundle between requesters and the shared counter
interface counter_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] target;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [CW-1:0]      count;
  logic               done;
  logic [2:0]         done_id;
  logic               abort;

  modport master (
    output req, target,
    input  gnt, busy, count, done, done_id, abort
  );

  modport slave (
    input  req, target,
    output gnt, busy, count, done, done_id, abort
  );
endinterface

// File: rtl/counter_share_arbiter_rr_arbiter.sv
// rtl/counter_share_arbiter_rr_arbiter.sv - combinational round-robin pick: first set request at or above ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_sel,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  always_comb begin
    o_sel   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!o_valid && i_req[(int'(i_ptr) + i) % NREQ]) begin
        o_valid = 1'b1;
        o_idx   = IW'((int'(i_ptr) + i) % NREQ);
        o_sel[(int'(i_ptr) + i) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_share_arbiter.sv
// rtl/counter_share_arbiter.sv - lends one up-counter to NREQ requesters in turn; counts each owner to its target
module counter_share_arbiter
  import counter_share_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic                  clock,
  input  logic                  clear,
  counter_share_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [CW-1:0]   r_tgt, w_tgt_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic            r_done, w_done_nxt;
  logic [2:0]      r_done_id, w_done_id_nxt;
  logic            r_abort, w_abort_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;

  logic [NREQ-1:0] w_arb_sel;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_valid;
  logic [IW-1:0]   w_owner_inc;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr_arbiter (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_sel   (w_arb_sel),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // The finishing owner drops to lowest priority on the next arbitration
  assign w_owner_inc = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + IW'(1);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_tgt     <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_abort   <= 1'b0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_tgt     <= w_tgt_nxt;
      r_count   <= w_count_nxt;
      r_done    <= w_done_nxt;
      r_done_id <= w_done_id_nxt;
      r_abort   <= w_abort_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_owner_nxt   = r_owner;
    w_tgt_nxt     = r_tgt;
    w_count_nxt   = r_count;
    w_done_nxt    = 1'b0;
    w_done_id_nxt = r_done_id;
    w_abort_nxt   = 1'b0;
    w_ptr_nxt     = r_ptr;
    case (r_state)
      ST_IDLE: begin
        w_count_nxt = '0;
        if (w_arb_valid) begin
          w_gnt_nxt   = w_arb_sel;
          w_owner_nxt = w_arb_idx;
          w_tgt_nxt   = bus.target[int'(w_arb_idx)*CW +: CW];
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abandon is checked first so a drop on the terminal cycle aborts rather than completes
        if (!bus.req[r_owner]) begin
          w_abort_nxt = 1'b1;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_owner_inc;
          w_count_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_count == r_tgt) begin
          w_done_nxt    = 1'b1;
          w_done_id_nxt = 3'(r_owner);
          w_gnt_nxt     = '0;
          w_state_nxt   = ST_DONE;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      ST_DONE: begin
        w_ptr_nxt   = w_owner_inc;
        w_count_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_count_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.count   = r_count;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.abort   = r_abort;

endmodule
